// File: rtl/preproc_pkg.sv
// rtl/preproc_pkg.sv - shared types and constants for the preprocessing sequencer
package preproc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int MAX_STAGES = 16;
  localparam int STG_W      = 4;

endpackage

// File: rtl/preproc_wdt.sv
// rtl/preproc_wdt.sv - per-stage stall counter with clear/enable and timeout flag
module preproc_wdt #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count RUN cycles spent in the current stage; holds at the limit so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = en && (cnt == LIMIT);

endmodule

// File: rtl/preproc_seq_ctrl.sv
// rtl/preproc_seq_ctrl.sv - configurable stage sequencer; optional stall watchdog via PREPROC_WDT_EN
module preproc_seq_ctrl
  import preproc_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-2:0] buf_en,
  output logic [NUM_STAGES-2:0] buf_rw,
  output logic [3:0]            cur_stage,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);

  state_t            state, state_n;
  logic [STG_W-1:0]  stg, stg_n;
  logic [MAX_STAGES-1:0] done_pad;
  logic              adv;
  logic              timeout;

  logic [NUM_STAGES-1:0] stage_en_n;
  logic [NUM_STAGES-2:0] buf_en_n;
  logic [NUM_STAGES-2:0] buf_rw_n;
  logic [3:0]            cur_stage_n;

  // Widen stage_done so any stage index selects a bit without a range overflow.
  assign done_pad = MAX_STAGES'(stage_done);
  assign adv      = (state == RUN) && done_pad[stg];

`ifdef PREPROC_WDT_EN
  preproc_wdt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state != RUN) || adv || abort),
    .en      (state == RUN),
    .timeout (timeout)
  );
`else
  wire unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout = 1'b0;
`endif

  // Next-state and stage-index selection; abort overrides every other event.
  always_comb begin
    state_n = state;
    stg_n   = stg;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          stg_n   = '0;
        end
      end
      RUN: begin
        if (adv) begin
          if (stg == LAST_STG) begin
            state_n = DONE;
            stg_n   = '0;
          end else begin
            stg_n = stg + 1'b1;
          end
        end else if (timeout) begin
          state_n = ERR;
        end
      end
      DONE: begin
        state_n = cont ? RUN : IDLE;
        stg_n   = '0;
      end
`ifdef PREPROC_WDT_EN
      ERR: begin
        if (start) begin
          state_n = RUN;
          stg_n   = '0;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        stg_n   = '0;
      end
    endcase
    if (abort) begin
      state_n = IDLE;
      stg_n   = '0;
    end
  end

  // Decode the upcoming state into output values so outputs register alongside it.
  always_comb begin
    stage_en_n  = '0;
    buf_en_n    = '0;
    buf_rw_n    = '0;
    cur_stage_n = '0;
    if (state_n == RUN) begin
      stage_en_n = NUM_STAGES'(1) << stg_n;
      for (int i = 0; i < NUM_STAGES - 1; i++) begin
        if (STG_W'(i) == stg_n) begin
          buf_en_n[i] = 1'b1;
          buf_rw_n[i] = 1'b1;
        end
        if (STG_W'(i + 1) == stg_n) begin
          buf_en_n[i] = 1'b1;
        end
      end
    end
    if ((state_n == RUN) || (state_n == ERR)) begin
      cur_stage_n = stg_n;
    end
  end

  // Sequencer state and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      stg        <= '0;
      stage_en   <= '0;
      buf_en     <= '0;
      buf_rw     <= '0;
      cur_stage  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      stg        <= stg_n;
      stage_en   <= stage_en_n;
      buf_en     <= buf_en_n;
      buf_rw     <= buf_rw_n;
      cur_stage  <= cur_stage_n;
      busy       <= (state_n == RUN);
      frame_done <= (state_n == DONE);
      err        <= (state_n == ERR);
    end
  end

endmodule

// File: tb/tb_preproc_seq_ctrl.sv
// tb/tb_preproc_seq_ctrl.sv - directed self-checking bench for preproc_seq_ctrl
module tb_preproc_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start_a = 0, cont_a = 0, abort_a = 0;
  logic [2:0] done_a = '0;
  logic [2:0] stage_en_a;
  logic [1:0] buf_en_a, buf_rw_a;
  logic [3:0] cur_a;
  logic       busy_a, fdone_a, err_a;

  logic       start_b = 0, cont_b = 0, abort_b = 0;
  logic [4:0] done_b = '0;
  logic [4:0] stage_en_b;
  logic [3:0] buf_en_b, buf_rw_b;
  logic [3:0] cur_b;
  logic       busy_b, fdone_b, err_b;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  preproc_seq_ctrl #(.NUM_STAGES(3), .TIMEOUT_CYC(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a), .abort(abort_a),
    .stage_done(done_a), .stage_en(stage_en_a), .buf_en(buf_en_a), .buf_rw(buf_rw_a),
    .cur_stage(cur_a), .busy(busy_a), .frame_done(fdone_a), .err(err_a)
  );

  preproc_seq_ctrl #(.NUM_STAGES(5), .TIMEOUT_CYC(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b), .abort(abort_b),
    .stage_done(done_b), .stage_en(stage_en_b), .buf_en(buf_en_b), .buf_rw(buf_rw_b),
    .cur_stage(cur_b), .busy(busy_b), .frame_done(fdone_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_stage_en", 32'(stage_en_a), 32'h0);
    chk("rst_buf_en", 32'(buf_en_a), 32'h0);
    chk("rst_buf_rw", 32'(buf_rw_a), 32'h0);
    chk("rst_cur", 32'(cur_a), 32'h0);
    chk("rst_busy_fd_err", {29'd0, busy_a, fdone_a, err_a}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_stage_en", 32'(stage_en_a), 32'h0);

    // single frame, one stage at a time
    start_a = 1; tick(); start_a = 0;
    chk("s0_stage_en", 32'(stage_en_a), 32'b001);
    chk("s0_buf_en", 32'(buf_en_a), 32'b01);
    chk("s0_buf_rw", 32'(buf_rw_a), 32'b01);
    chk("s0_busy", 32'(busy_a), 32'h1);
    done_a = 3'b100; tick(); done_a = 0;
    chk("ignore_other_done", 32'(stage_en_a), 32'b001);
    chk("ignore_cur", 32'(cur_a), 32'h0);
    done_a = 3'b001; tick(); done_a = 0;
    chk("s1_stage_en", 32'(stage_en_a), 32'b010);
    chk("s1_buf_en", 32'(buf_en_a), 32'b11);
    chk("s1_buf_rw", 32'(buf_rw_a), 32'b10);
    chk("s1_cur", 32'(cur_a), 32'h1);
    done_a = 3'b010; tick(); done_a = 0;
    chk("s2_stage_en", 32'(stage_en_a), 32'b100);
    chk("s2_buf_en", 32'(buf_en_a), 32'b10);
    chk("s2_buf_rw", 32'(buf_rw_a), 32'b00);
    chk("s2_cur", 32'(cur_a), 32'h2);
    done_a = 3'b100; tick(); done_a = 0;
    chk("fd_pulse", 32'(fdone_a), 32'h1);
    chk("fd_stage_en", 32'(stage_en_a), 32'h0);
    chk("fd_buf_en", 32'(buf_en_a), 32'h0);
    chk("fd_busy", 32'(busy_a), 32'h0);
    tick();
    chk("fd_one_cycle", 32'(fdone_a), 32'h0);
    chk("back_idle_busy", 32'(busy_a), 32'h0);

    // continuous mode, three back-to-back frames
    cont_a = 1; start_a = 1; tick(); start_a = 0;
    pulses = 0;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 3; s++) begin
        chk("cont_busy_run", 32'(busy_a), 32'h1);
        done_a = 3'(1 << s); tick(); done_a = 0;
      end
      if (fdone_a) pulses++;
      chk("cont_busy_done", 32'(busy_a), 32'h0);
      if (f == 2) cont_a = 0;
      tick();
      chk("cont_restart", 32'(stage_en_a), (f < 2) ? 32'b001 : 32'h0);
    end
    chk("cont_pulses", 32'(pulses), 32'd3);

    // abort beats a same-cycle done
    start_a = 1; tick(); start_a = 0;
    done_a = 3'b001; abort_a = 1; tick(); done_a = 0; abort_a = 0;
    chk("abort_stage_en", 32'(stage_en_a), 32'h0);
    chk("abort_busy", 32'(busy_a), 32'h0);
    chk("abort_cur", 32'(cur_a), 32'h0);
    tick();
    chk("abort_stays_idle", 32'(stage_en_a), 32'h0);

    // five stages, asynchronous reset during stage 3
    start_b = 1; tick(); start_b = 0;
    for (int s = 0; s < 3; s++) begin
      done_b = 5'(1 << s); tick(); done_b = 0;
    end
    chk("b_s3_stage_en", 32'(stage_en_b), 32'b01000);
    chk("b_s3_buf_en", 32'(buf_en_b), 32'b1100);
    chk("b_s3_buf_rw", 32'(buf_rw_b), 32'b1000);
    chk("b_s3_cur", 32'(cur_b), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("b_arst_stage_en", 32'(stage_en_b), 32'h0);
    chk("b_arst_buf", {24'd0, buf_en_b, buf_rw_b}, 32'h0);
    chk("b_arst_misc", {25'd0, cur_b, busy_b, fdone_b, err_b}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("b_no_fd_after_rst", 32'(fdone_b), 32'h0);
    start_b = 1; tick(); start_b = 0;
    chk("b_restart_stage_en", 32'(stage_en_b), 32'b00001);
    chk("b_restart_cur", 32'(cur_b), 32'h0);
    abort_b = 1; tick(); abort_b = 0;

`ifdef PREPROC_WDT_EN
    // stall in stage 1 until the watchdog fires
    start_a = 1; tick(); start_a = 0;
    done_a = 3'b001; tick(); done_a = 0;
    repeat (7) tick();
    chk("wdt_still_run", 32'(busy_a), 32'h1);
    chk("wdt_no_err_yet", 32'(err_a), 32'h0);
    tick();
    chk("wdt_err", 32'(err_a), 32'h1);
    chk("wdt_stage_en", 32'(stage_en_a), 32'h0);
    chk("wdt_buf_en", 32'(buf_en_a), 32'h0);
    chk("wdt_cur", 32'(cur_a), 32'h1);
    chk("wdt_busy", 32'(busy_a), 32'h0);
    start_a = 1; tick(); start_a = 0;
    chk("wdt_clear_err", 32'(err_a), 32'h0);
    chk("wdt_restart", 32'(stage_en_a), 32'b001);
    abort_a = 1; tick(); abort_a = 0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
